// File: rtl/ddr_bank_responder_pkg.sv
// Shared types and default timing for the DDR4 bank responder.
// The decoded command set, the per-bank FSM states and the READ/WRITE
// tag handed to the data model all live here, so the top level and the
// per-bank FSM agree on encodings.
package ddr_bank_responder_pkg;

  localparam int NUMBER_BANK = 16;
  localparam int RA_WIDTH    = 15;
  localparam int CA_WIDTH    = 10;
  localparam int T_RCD       = 15;
  localparam int T_RP        = 15;
  localparam int T_RAS       = 33;
  localparam int CNT_WIDTH   = 8;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } command_type;

  typedef enum logic [1:0] {
    BANK_IDLE,
    BANK_ACTIVATING,
    BANK_ACTIVE,
    BANK_PRECHARGING
  } bank_state_type;

  typedef enum logic [2:0] {
    DEC_NOP,
    DEC_ACT,
    DEC_PRE,
    DEC_PREA,
    DEC_RD,
    DEC_WR,
    DEC_REF
  } dec_cmd_type;

endpackage

// File: rtl/ddr_bank_responder_bank_fsm.sv
// One bank of the responder: open-row tracking plus tRCD/tRP/tRAS checks.
// Ports:
//   clock_t, reset_n : clock, synchronous active-low reset
//   cmd, sel, row_in : decoded command, this-bank select, row for ACT
//   state, row       : current bank state and latched open row
//   act_ready        : an ACT issued now would be legal (also "idle" for REF)
//   cas_ok           : RD/WR issued now is accepted (combinational strobe)
//   act_err/cas_err/pre_err : protocol-violation strobes for this command
module ddr_bank_responder_bank_fsm #(
  parameter int RA_WIDTH  = ddr_bank_responder_pkg::RA_WIDTH,
  parameter int CNT_WIDTH = ddr_bank_responder_pkg::CNT_WIDTH,
  parameter int T_RCD     = ddr_bank_responder_pkg::T_RCD,
  parameter int T_RP      = ddr_bank_responder_pkg::T_RP,
  parameter int T_RAS     = ddr_bank_responder_pkg::T_RAS
) (
  input  logic                                   clock_t,
  input  logic                                   reset_n,
  input  ddr_bank_responder_pkg::dec_cmd_type    cmd,
  input  logic                                   sel,
  input  logic [RA_WIDTH-1:0]                    row_in,
  output ddr_bank_responder_pkg::bank_state_type state,
  output logic [RA_WIDTH-1:0]                    row,
  output logic                                   act_ready,
  output logic                                   cas_ok,
  output logic                                   act_err,
  output logic                                   cas_err,
  output logic                                   pre_err
);
  import ddr_bank_responder_pkg::*;

  // Timers hold "cycles since entry minus one" at the sampling edge, so a
  // command N cycles after the event sees the timer at N-1.
  localparam logic [CNT_WIDTH-1:0] RCD_LAST = CNT_WIDTH'(T_RCD - 1);
  localparam logic [CNT_WIDTH-1:0] RP_LAST  = CNT_WIDTH'(T_RP - 1);
  localparam logic [CNT_WIDTH-1:0] RAS_LAST = CNT_WIDTH'(T_RAS - 1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  bank_state_type       state_nxt;
  logic [CNT_WIDTH-1:0] timer;
  logic [CNT_WIDTH-1:0] ras_timer;
  logic                 row_load;
  logic                 act_cmd, cas_cmd, pre_cmd;
  logic                 rcd_done, rp_done, ras_done, cas_ready;

  assign act_cmd  = sel && (cmd == DEC_ACT);
  assign cas_cmd  = sel && ((cmd == DEC_RD) || (cmd == DEC_WR));
  assign pre_cmd  = (sel && (cmd == DEC_PRE)) || (cmd == DEC_PREA);
  assign rcd_done = (timer >= RCD_LAST);
  assign rp_done  = (timer >= RP_LAST);
  assign ras_done = (ras_timer >= RAS_LAST);

  // The last cycle of ACTIVATING/PRECHARGING already counts as the next
  // state for legality, so commands exactly tRCD/tRP later are accepted.
  assign act_ready = (state == BANK_IDLE) || ((state == BANK_PRECHARGING) && rp_done);
  assign cas_ready = (state == BANK_ACTIVE) || ((state == BANK_ACTIVATING) && rcd_done);

  always_comb begin
    state_nxt = state;
    row_load  = 1'b0;
    cas_ok    = 1'b0;
    act_err   = 1'b0;
    cas_err   = 1'b0;
    pre_err   = 1'b0;

    case (state)
      BANK_ACTIVATING: begin
        if (rcd_done) state_nxt = BANK_ACTIVE;
        if (pre_cmd)  pre_err   = 1'b1;
      end
      BANK_ACTIVE: begin
        if (pre_cmd) begin
          if (ras_done) state_nxt = BANK_PRECHARGING;
          else          pre_err   = 1'b1;
        end
      end
      BANK_PRECHARGING: begin
        if (rp_done) state_nxt = BANK_IDLE;
      end
      default: ;
    endcase

    // ACT overrides the timed exit from PRECHARGING when it lands on the
    // final precharge cycle.
    if (act_cmd) begin
      if (act_ready) begin
        state_nxt = BANK_ACTIVATING;
        row_load  = 1'b1;
      end else begin
        act_err = 1'b1;
      end
    end

    if (cas_cmd) begin
      if (cas_ready) cas_ok  = 1'b1;
      else           cas_err = 1'b1;
    end
  end

  always_ff @(posedge clock_t) begin
    if (!reset_n) begin
      state     <= BANK_IDLE;
      timer     <= '0;
      ras_timer <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= (state_nxt != state) ? '0 : sat_inc(timer);
      ras_timer <= row_load ? '0 : sat_inc(ras_timer);
    end
  end

  always_ff @(posedge clock_t) begin
    if (row_load) row <= row_in;
  end

endmodule

// File: rtl/ddr_bank_responder.sv
// Memory-side DDR4 command responder: decodes the command pins, tracks
// per-bank open rows, and forwards each legal RD/WR with its open row.
// Ports:
//   clock_t, reset_n          : clock, synchronous active-low reset
//   cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14, bg, ba, addr : command bus
//   cas_valid/rw/bank/row/col : accepted column command (one-cycle pulse,
//                               fields hold between pulses)
//   bank_open                 : per bank, set while ACTIVATING or ACTIVE
//   err_act/cas/pre/ref       : protocol-violation pulses
module ddr_bank_responder #(
  parameter int NUMBER_BANK = ddr_bank_responder_pkg::NUMBER_BANK,
  parameter int RA_WIDTH    = ddr_bank_responder_pkg::RA_WIDTH,
  parameter int CA_WIDTH    = ddr_bank_responder_pkg::CA_WIDTH,
  parameter int T_RCD       = ddr_bank_responder_pkg::T_RCD,
  parameter int T_RP        = ddr_bank_responder_pkg::T_RP,
  parameter int T_RAS       = ddr_bank_responder_pkg::T_RAS,
  parameter int CNT_WIDTH   = ddr_bank_responder_pkg::CNT_WIDTH
) (
  input  logic                                clock_t,
  input  logic                                reset_n,
  input  logic                                cs_n,
  input  logic                                act_n,
  input  logic                                ras_n_a16,
  input  logic                                cas_n_a15,
  input  logic                                we_n_a14,
  input  logic [1:0]                          bg,
  input  logic [1:0]                          ba,
  input  logic [13:0]                         addr,
  output logic                                cas_valid,
  output ddr_bank_responder_pkg::command_type cas_rw,
  output logic [3:0]                          cas_bank,
  output logic [RA_WIDTH-1:0]                 cas_row,
  output logic [CA_WIDTH-1:0]                 cas_col,
  output logic [NUMBER_BANK-1:0]              bank_open,
  output logic                                err_act,
  output logic                                err_cas,
  output logic                                err_pre,
  output logic                                err_ref
);
  import ddr_bank_responder_pkg::*;

  dec_cmd_type          cmd;
  logic [3:0]           bank_sel;
  logic [RA_WIDTH-1:0]  act_row;
  bank_state_type       bank_state [NUMBER_BANK];
  logic [RA_WIDTH-1:0]  bank_row   [NUMBER_BANK];
  logic [NUMBER_BANK-1:0] act_rdy, cas_hit, act_e, cas_e, pre_e;

  assign bank_sel = {bg, ba};
  // On ACT the RAS/CAS/WE pins carry A16..A14; the row keeps the low bits.
  assign act_row  = RA_WIDTH'({ras_n_a16, cas_n_a15, we_n_a14, addr});

  always_comb begin
    cmd = DEC_NOP;
    if (!cs_n) begin
      if (!act_n) begin
        cmd = DEC_ACT;
      end else begin
        case ({ras_n_a16, cas_n_a15, we_n_a14})
          3'b010:  cmd = addr[10] ? DEC_PREA : DEC_PRE;
          3'b100:  cmd = DEC_WR;
          3'b101:  cmd = DEC_RD;
          3'b001:  cmd = DEC_REF;
          default: cmd = DEC_NOP;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < NUMBER_BANK; gi++) begin : g_bank
    ddr_bank_responder_bank_fsm #(
      .RA_WIDTH (RA_WIDTH),
      .CNT_WIDTH(CNT_WIDTH),
      .T_RCD    (T_RCD),
      .T_RP     (T_RP),
      .T_RAS    (T_RAS)
    ) u_bank (
      .clock_t  (clock_t),
      .reset_n  (reset_n),
      .cmd      (cmd),
      .sel      (bank_sel == 4'(gi)),
      .row_in   (act_row),
      .state    (bank_state[gi]),
      .row      (bank_row[gi]),
      .act_ready(act_rdy[gi]),
      .cas_ok   (cas_hit[gi]),
      .act_err  (act_e[gi]),
      .cas_err  (cas_e[gi]),
      .pre_err  (pre_e[gi])
    );
    assign bank_open[gi] = (bank_state[gi] == BANK_ACTIVATING) ||
                           (bank_state[gi] == BANK_ACTIVE);
  end

  // Only the selected bank can raise act/cas strobes; PREA may hit several
  // banks at once but is reported as a single err_pre pulse.
  always_ff @(posedge clock_t) begin
    if (!reset_n) begin
      cas_valid <= 1'b0;
      cas_rw    <= READ;
      cas_bank  <= '0;
      cas_row   <= '0;
      cas_col   <= '0;
      err_act   <= 1'b0;
      err_cas   <= 1'b0;
      err_pre   <= 1'b0;
      err_ref   <= 1'b0;
    end else begin
      cas_valid <= |cas_hit;
      if (|cas_hit) begin
        cas_rw   <= (cmd == DEC_WR) ? WRITE : READ;
        cas_bank <= bank_sel;
        cas_row  <= bank_row[bank_sel];
        cas_col  <= addr[CA_WIDTH-1:0];
      end
      err_act <= |act_e;
      err_cas <= |cas_e;
      err_pre <= |pre_e;
      err_ref <= (cmd == DEC_REF) && !(&act_rdy);
    end
  end

endmodule

// File: tb/tb_ddr_bank_responder.sv
module tb_ddr_bank_responder;
  import ddr_bank_responder_pkg::*;

  logic        clock_t = 1'b0;
  logic        reset_n, cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14;
  logic [1:0]  bg, ba;
  logic [13:0] addr;
  logic        cas_valid;
  command_type cas_rw;
  logic [3:0]  cas_bank;
  logic [14:0] cas_row;
  logic [9:0]  cas_col;
  logic [15:0] bank_open;
  logic        err_act, err_cas, err_pre, err_ref;

  always #5 clock_t = ~clock_t;

  ddr_bank_responder dut (
    .clock_t  (clock_t),
    .reset_n  (reset_n),
    .cs_n     (cs_n),
    .act_n    (act_n),
    .ras_n_a16(ras_n_a16),
    .cas_n_a15(cas_n_a15),
    .we_n_a14 (we_n_a14),
    .bg       (bg),
    .ba       (ba),
    .addr     (addr),
    .cas_valid(cas_valid),
    .cas_rw   (cas_rw),
    .cas_bank (cas_bank),
    .cas_row  (cas_row),
    .cas_col  (cas_col),
    .bank_open(bank_open),
    .err_act  (err_act),
    .err_cas  (err_cas),
    .err_pre  (err_pre),
    .err_ref  (err_ref)
  );

  typedef struct {
    logic [4:0]  flags;  // {cas_valid, err_act, err_cas, err_pre, err_ref}
    command_type rw;
    logic [3:0]  bank;
    logic [14:0] row;
    logic [9:0]  col;
    int          due;
  } exp_t;

  localparam logic [4:0] F_CAS  = 5'b10000;
  localparam logic [4:0] F_ACT  = 5'b01000;
  localparam logic [4:0] F_CASE = 5'b00100;
  localparam logic [4:0] F_PRE  = 5'b00010;
  localparam logic [4:0] F_REF  = 5'b00001;
  localparam logic [2:0] C_PRE  = 3'b010;
  localparam logic [2:0] C_WR   = 3'b100;
  localparam logic [2:0] C_RD   = 3'b101;
  localparam logic [2:0] C_REF  = 3'b001;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clock_t) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clock_t);
    #1;
    cs_n = 1'b1; act_n = 1'b1;
    ras_n_a16 = 1'b1; cas_n_a15 = 1'b1; we_n_a14 = 1'b1;
    addr = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic act(input logic [3:0] b, input logic [14:0] r);
    cs_n = 1'b0; act_n = 1'b0;
    ras_n_a16 = 1'b0; cas_n_a15 = 1'b0; we_n_a14 = r[14];
    addr = r[13:0];
    {bg, ba} = b;
    tick();
  endtask

  task automatic cmd(input logic [2:0] code, input logic [3:0] b,
                     input logic [13:0] a, input logic selected);
    cs_n = ~selected; act_n = 1'b1;
    {ras_n_a16, cas_n_a15, we_n_a14} = code;
    {bg, ba} = b;
    addr = a;
    tick();
  endtask

  // Expected output appears the cycle after the command edge.
  task automatic expect_ev(input logic [4:0] f, input command_type rw,
                           input logic [3:0] b, input logic [14:0] r,
                           input logic [9:0] c);
    exp_t e;
    e.flags = f; e.rw = rw; e.bank = b; e.row = r; e.col = c;
    e.due = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic expect_err(input logic [4:0] f);
    expect_ev(f, READ, 4'h0, 15'h0, 10'h0);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic do_reset(input string name);
    reset_n = 1'b0;
    tick();
    check({name, "_outputs"},
          {cas_valid, cas_rw, cas_bank, cas_row, cas_col, err_act, err_cas, err_pre, err_ref},
          64'h0);
    check({name, "_bank_open"}, bank_open, 64'h0);
    reset_n = 1'b1;
  endtask

  // Scoreboard monitor: every output pulse must match the oldest expectation.
  always @(negedge clock_t) begin
    logic [4:0] f;
    exp_t       e;
    logic       ok;
    f = {cas_valid, err_act, err_cas, err_pre, err_ref};
    if (!$isunknown(f) && f != 5'b0) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got flags=%b at cycle %0d, required no output", f, cyc);
      end else begin
        e  = sb.pop_front();
        ok = (f == e.flags) && (cyc == e.due);
        if (e.flags[4])
          ok = ok && (cas_rw == e.rw) && (cas_bank == e.bank) &&
               (cas_row == e.row) && (cas_col == e.col);
        if (!ok) begin
          n_fail++;
          $display("FAIL response: got flags=%b rw=%0d bank=%0h row=%0h col=%0h cyc=%0d required flags=%b rw=%0d bank=%0h row=%0h col=%0h cyc=%0d",
                   f, cas_rw, cas_bank, cas_row, cas_col, cyc,
                   e.flags, e.rw, e.bank, e.row, e.col, e.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; cs_n = 1'b1; act_n = 1'b1;
    ras_n_a16 = 1'b1; cas_n_a15 = 1'b1; we_n_a14 = 1'b1;
    bg = '0; ba = '0; addr = '0;
    repeat (2) @(posedge clock_t);
    #1;

    // Read exactly tRCD after ACT; deselected RD before it is ignored.
    do_reset("reset1");
    act(4'd5, 15'h1234);
    idle(13);
    cmd(C_RD, 4'd5, 14'h020, 1'b0);
    expect_ev(F_CAS, READ, 4'd5, 15'h1234, 10'h020);
    cmd(C_RD, 4'd5, 14'h020, 1'b1);
    check("t1_bank_open", bank_open, 64'h0020);

    // Write one cycle early is rejected, at tRCD accepted.
    do_reset("reset2");
    act(4'd2, 15'h0abc);
    idle(13);
    expect_err(F_CASE);
    cmd(C_WR, 4'd2, 14'h3ff, 1'b1);
    expect_ev(F_CAS, WRITE, 4'd2, 15'h0abc, 10'h3ff);
    cmd(C_WR, 4'd2, 14'h3ff, 1'b1);

    // tRAS and tRP boundaries on bank 3.
    do_reset("reset3");
    act(4'd3, 15'h7fff);
    idle(19);
    expect_err(F_PRE);
    cmd(C_PRE, 4'd3, 14'h0, 1'b1);
    check("t3_open_after_early_pre", bank_open, 64'h0008);
    idle(12);
    cmd(C_PRE, 4'd3, 14'h0, 1'b1);
    check("t3_closed_after_pre", bank_open, 64'h0000);
    idle(13);
    expect_err(F_ACT);
    act(4'd3, 15'h0042);
    act(4'd3, 15'h0042);
    check("t3_reopened", bank_open, 64'h0008);
    idle(14);
    expect_ev(F_CAS, READ, 4'd3, 15'h0042, 10'h001);
    cmd(C_RD, 4'd3, 14'h001, 1'b1);
    cmd(3'b011, 4'd3, 14'h0, 1'b1);

    // PREA on two legal banks, then REF inside and at tRP.
    do_reset("reset4");
    act(4'd0, 15'h0001);
    act(4'd9, 15'h0009);
    idle(40);
    check("t4_two_open", bank_open, 64'h0201);
    cmd(C_PRE, 4'd0, 14'h0400, 1'b1);
    idle(9);
    expect_err(F_REF);
    cmd(C_REF, 4'd0, 14'h0, 1'b1);
    idle(4);
    cmd(C_REF, 4'd0, 14'h0, 1'b1);
    check("t4_all_closed", bank_open, 64'h0000);

    // PREA with one legal and one too-young bank: single err_pre.
    do_reset("reset5");
    act(4'd0, 15'h0001);
    idle(31);
    act(4'd1, 15'h0002);
    expect_err(F_PRE);
    cmd(C_PRE, 4'd0, 14'h0400, 1'b1);
    check("t4b_young_bank_open", bank_open, 64'h0002);

    // Double ACT keeps the original row.
    do_reset("reset6");
    act(4'd7, 15'h0111);
    idle(19);
    expect_err(F_ACT);
    act(4'd7, 15'h2222);
    expect_ev(F_CAS, READ, 4'd7, 15'h0111, 10'h005);
    cmd(C_RD, 4'd7, 14'h005, 1'b1);

    // Reset while bank 1 is active discards the open row.
    act(4'd1, 15'h0055);
    idle(20);
    check("t6_open_before_reset", bank_open[1], 64'h1);
    do_reset("reset_mid");
    expect_err(F_CASE);
    cmd(C_RD, 4'd1, 14'h001, 1'b1);

    idle(3);
    check("scoreboard_drained", sb.size(), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_bank_responder.md
Name: ddr_bank_responder

Overview:
- Memory-side responder for the DDR4 command bus driven by the controller's ACT/CAS/PRE sequencers.
- Decodes ACT, PRE, PREA, RD, WR and REF from the command pins and tracks per-bank open-row state.
- Enforces tRCD, tRP and tRAS, and hands each legal column command to the memory data model with its open row.
- Flags protocol violations for the verification scoreboard.

Parameters:
- NUMBER_BANK, 16, banks addressed as {bg,ba}
- RA_WIDTH, 15, row address width
- CA_WIDTH, 10, column address width
- T_RCD, 15, min cycles ACT→RD/WR same bank
- T_RP, 15, min cycles PRE→ACT same bank
- T_RAS, 33, min cycles ACT→PRE same bank
- CNT_WIDTH, 8, per-bank timer width (saturating)

Ports:
- clock_t  in  1  main clock (all logic on posedge)
- reset_n  in  1  synchronous active-low reset
- cs_n  in  1  chip select, command valid when 0
- act_n  in  1  activate strobe
- ras_n_a16  in  1  RAS_n / A16
- cas_n_a15  in  1  CAS_n / A15
- we_n_a14  in  1  WE_n / A14
- bg  in  2  bank group
- ba  in  2  bank address
- addr  in  14  A13..A0 (A10 = AP on PRE)
- cas_valid  out  1  one-cycle pulse: legal RD/WR accepted
- cas_rw  out  command_type  READ or WRITE
- cas_bank  out  4  {bg,ba} of accepted CAS
- cas_row  out  RA_WIDTH  open row of that bank
- cas_col  out  CA_WIDTH  addr[9:0]
- bank_open  out  NUMBER_BANK  bit set while bank ACTIVE or ACTIVATING
- err_act  out  1  ACT to bank not IDLE
- err_cas  out  1  RD/WR to bank not ACTIVE
- err_pre  out  1  PRE before tRAS expired
- err_ref  out  1  REF while any bank not IDLE

Behaviour:
- Reset (reset_n=0 at posedge): all banks IDLE, timers 0, every output 0; mid-operation reset discards all open rows.
- Decode when cs_n=0:
  - act_n=0 → ACT, row = {we_n_a14, addr}.
  - act_n=1, {ras,cas,we} = 010 → PRE (addr[10]=1 → PREA, all banks).
  - 100 → WR; 101 → RD; 001 → REF.
  - All other codes, and cs_n=1, → NOP.
- Bank FSM states: IDLE, ACTIVATING, ACTIVE, PRECHARGING. Timer clears on each state entry and increments per cycle, saturating at all-ones.
- IDLE:
  - ACT → ACTIVATING; latch row.
  - PRE → stay IDLE, no error.
- ACTIVATING → ACTIVE when timer reaches T_RCD-1. A RD/WR is legal when issued T_RCD or more cycles after the ACT.
- ACTIVE:
  - RD/WR → cas_valid.
  - PRE → PRECHARGING if cycles since ACT ≥ T_RAS; otherwise err_pre and bank stays ACTIVE.
  - A separate tRAS timer starts at ACT and runs through ACTIVATING/ACTIVE.
- PRE while ACTIVATING → err_pre, ignored.
- PRECHARGING → IDLE when timer reaches T_RP-1. ACT is legal T_RP or more cycles after the PRE.
- PREA applies PRE to every bank independently: IDLE banks no-op, early banks flag err_pre (one pulse total), legal banks precharge.
- Illegal commands:
  - ACT to non-IDLE bank → err_act; state and row unchanged.
  - RD/WR to non-ACTIVE bank → err_cas; no cas_valid.
  - REF with any bank not IDLE → err_ref; REF otherwise no-op.
- Output timing: all outputs registered. cas_* and err_* are one-cycle pulses asserted the cycle after the command edge. cas_* hold their values between pulses.
- One command per cycle by construction. Errors and cas_valid are never both set for the same command.

Decomposition:
- ddr_package additions:
  - bank_state_type enum {BANK_IDLE, BANK_ACTIVATING, BANK_ACTIVE, BANK_PRECHARGING}
  - dec_cmd_type enum {DEC_NOP, DEC_ACT, DEC_PRE, DEC_PREA, DEC_RD, DEC_WR, DEC_REF}
  - reuse command_type READ/WRITE, NUMBER_BANK, RA_WIDTH, tRP
- Sub-module bank_fsm: one instance per bank.
  - Inputs: decoded cmd + select + row.
  - Outputs: state, row, act/cas/pre error strobes.
- Top level holds the decoder, the generate loop, and error/CAS muxing.

Test Plan:
- ACT bank 5 row 0x1234 at cycle 0, RD bank 5 col 0x20 at cycle 15 → cycle 16: cas_valid=1, cas_rw=READ, cas_bank=5, cas_row=0x1234, cas_col=0x20; bank_open[5]=1.
- ACT bank 2 at cycle 0, WR bank 2 at cycle 14 → err_cas pulse cycle 15, no cas_valid. Repeat WR at cycle 15 → cas_valid cycle 16.
- ACT bank 3 cycle 0, PRE cycle 20 → err_pre, bank_open[3] stays 1. PRE cycle 33 → bank_open[3]=0 cycle 34. ACT cycle 47 → err_act; ACT cycle 48 → accepted.
- ACT banks 0 and 9, wait 40 cycles, PREA (addr[10]=1), REF at +10 → err_ref. REF at +15 → no error; all bank_open=0.
- ACT bank 7, then ACT bank 7 again at cycle 20 → err_act, row unchanged (checked via subsequent RD cas_row).
- Reset asserted while bank 1 is ACTIVE → next cycle bank_open=0, all outputs 0. RD bank 1 after reset release → err_cas.
